// File: rtl/pwm_counter_gen.sv
// PWM timebase counter: up, down and centre-aligned modes with shadowed settings.
// Optional PWM_CNT_REPEAT_EN adds a repetition count that thins out update events.
module pwm_counter_gen #(
   parameter int CNT_W = 16,
   parameter int PSC_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             count_reset,
   input  logic [1:0]       mode,
   input  logic [CNT_W-1:0] period,
   input  logic [PSC_W-1:0] prescale,
   input  logic             one_shot,
`ifdef PWM_CNT_REPEAT_EN
   input  logic [7:0]       repeat_val,
`endif
   output logic [CNT_W-1:0] count_val,
   output logic             dir,
   output logic             ovf_pulse,
   output logic             unf_pulse,
   output logic             upd_pulse,
   output logic             done
);

   typedef enum logic [1:0] {
      M_UP   = 2'b00,
      M_DOWN = 2'b01,
      M_CTR  = 2'b10,
      M_UP3  = 2'b11
   } mode_e;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic [PSC_W-1:0] psc_q, psc_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             upd_q, upd_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] per_sh_q, per_sh_d;
   logic [PSC_W-1:0] psc_sh_q, psc_sh_d;
   mode_e            mode_sh_q, mode_sh_d;
   logic             os_sh_q, os_sh_d;
`ifdef PWM_CNT_REPEAT_EN
   logic [7:0]       rep_sh_q, rep_sh_d;
   logic [7:0]       rep_q, rep_d;
`endif

   logic tick;
   logic base_ev;
   logic upd_ev;

   // Next-state: count_reset first, then prescaler tick, mode step and update event
   always_comb begin
      cnt_d     = cnt_q;
      dir_d     = dir_q;
      psc_d     = psc_q;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
      upd_d     = 1'b0;
      done_d    = done_q;
      per_sh_d  = per_sh_q;
      psc_sh_d  = psc_sh_q;
      mode_sh_d = mode_sh_q;
      os_sh_d   = os_sh_q;
`ifdef PWM_CNT_REPEAT_EN
      rep_sh_d  = rep_sh_q;
      rep_d     = rep_q;
`endif
      tick      = en && !done_q && (psc_q == psc_sh_q);
      base_ev   = 1'b0;
      upd_ev    = 1'b0;

      if (count_reset) begin
         per_sh_d  = period;
         psc_sh_d  = prescale;
         mode_sh_d = mode_e'(mode);
         os_sh_d   = one_shot;
`ifdef PWM_CNT_REPEAT_EN
         rep_sh_d  = repeat_val;
         rep_d     = '0;
`endif
         psc_d     = '0;
         done_d    = 1'b0;
         cnt_d     = (mode == M_DOWN) ? period : '0;
         dir_d     = (mode != M_DOWN);
      end else if (en && !done_q) begin
         if (!tick) begin
            psc_d = psc_q + 1'b1;
         end else begin
            psc_d = '0;
            case (mode_sh_q)
               M_DOWN: begin
                  if (cnt_q != '0) begin
                     cnt_d = cnt_q - 1'b1;
                  end else begin
                     cnt_d   = per_sh_q;
                     unf_d   = 1'b1;
                     base_ev = 1'b1;
                  end
               end
               M_CTR: begin
                  if (per_sh_q == '0) begin
                     cnt_d = '0;
                     dir_d = 1'b1;
                     ovf_d = 1'b1;
                  end else if (dir_q) begin
                     if (cnt_q < per_sh_q) begin
                        cnt_d = cnt_q + 1'b1;
                     end else begin
                        cnt_d = per_sh_q - 1'b1;
                        dir_d = 1'b0;
                        ovf_d = 1'b1;
                     end
                  end else if (cnt_q != '0) begin
                     cnt_d = cnt_q - 1'b1;
                  end else begin
                     cnt_d   = CNT_W'(1);
                     dir_d   = 1'b1;
                     unf_d   = 1'b1;
                     base_ev = 1'b1;
                  end
               end
               default: begin
                  if (cnt_q < per_sh_q) begin
                     cnt_d = cnt_q + 1'b1;
                  end else begin
                     cnt_d   = '0;
                     ovf_d   = 1'b1;
                     base_ev = 1'b1;
                  end
               end
            endcase

`ifdef PWM_CNT_REPEAT_EN
            if (base_ev) begin
               if (rep_q == rep_sh_q) begin
                  upd_ev = 1'b1;
                  rep_d  = '0;
               end else begin
                  rep_d  = rep_q + 1'b1;
               end
            end
`else
            upd_ev = base_ev;
`endif

            if (upd_ev) begin
               upd_d     = 1'b1;
               done_d    = os_sh_q;
               per_sh_d  = period;
               psc_sh_d  = prescale;
               mode_sh_d = mode_e'(mode);
               os_sh_d   = one_shot;
`ifdef PWM_CNT_REPEAT_EN
               rep_sh_d  = repeat_val;
`endif
               dir_d     = (mode != M_DOWN);
               // a down-mode reload takes the freshly loaded period
               if (mode_sh_q == M_DOWN) begin
                  cnt_d = period;
               end
            end
         end
      end
   end

   // State and shadow registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         dir_q     <= 1'b1;
         psc_q     <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         upd_q     <= 1'b0;
         done_q    <= 1'b0;
         per_sh_q  <= '0;
         psc_sh_q  <= '0;
         mode_sh_q <= M_UP;
         os_sh_q   <= 1'b0;
`ifdef PWM_CNT_REPEAT_EN
         rep_sh_q  <= '0;
         rep_q     <= '0;
`endif
      end else begin
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         psc_q     <= psc_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         upd_q     <= upd_d;
         done_q    <= done_d;
         per_sh_q  <= per_sh_d;
         psc_sh_q  <= psc_sh_d;
         mode_sh_q <= mode_sh_d;
         os_sh_q   <= os_sh_d;
`ifdef PWM_CNT_REPEAT_EN
         rep_sh_q  <= rep_sh_d;
         rep_q     <= rep_d;
`endif
      end
   end

   assign count_val = cnt_q;
   assign dir       = dir_q;
   assign ovf_pulse = ovf_q;
   assign unf_pulse = unf_q;
   assign upd_pulse = upd_q;
   assign done      = done_q;

endmodule

// File: tb/tb_pwm_counter_gen.sv
// Directed bench for pwm_counter_gen: vector table plus multi-cycle sequences.
// Expected values are hand-computed from the counting rules.
module tb_pwm_counter_gen;

   localparam int CW = 8;
   localparam int PW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          count_reset;
   logic [1:0]    mode;
   logic [CW-1:0] period;
   logic [PW-1:0] prescale;
   logic          one_shot;
`ifdef PWM_CNT_REPEAT_EN
   logic [7:0]    repeat_val;
`endif
   logic [CW-1:0] count_val;
   logic          dir;
   logic          ovf_pulse;
   logic          unf_pulse;
   logic          upd_pulse;
   logic          done;

   int checks = 0;
   int errors = 0;

   pwm_counter_gen #(.CNT_W(CW), .PSC_W(PW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .count_reset (count_reset),
      .mode        (mode),
      .period      (period),
      .prescale    (prescale),
      .one_shot    (one_shot),
`ifdef PWM_CNT_REPEAT_EN
      .repeat_val  (repeat_val),
`endif
      .count_val   (count_val),
      .dir         (dir),
      .ovf_pulse   (ovf_pulse),
      .unf_pulse   (unf_pulse),
      .upd_pulse   (upd_pulse),
      .done        (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          en;
      logic          cr;
      logic [1:0]    mode;
      logic [CW-1:0] per;
      logic [PW-1:0] psc;
      logic          os;
      logic [CW-1:0] cnt;
      logic          dir;
      logic          ovf;
      logic          unf;
      logic          upd;
      logic          done;
   } vec_t;

   vec_t tv[$];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic cr, input logic [1:0] m,
                        input logic [CW-1:0] p, input logic [PW-1:0] ps,
                        input logic os);
      en          = e;
      count_reset = cr;
      mode        = m;
      period      = p;
      prescale    = ps;
      one_shot    = os;
      step();
   endtask

   task automatic expect_out(input string name, input logic [CW-1:0] c,
                             input logic d, input logic o, input logic u,
                             input logic up, input logic dn);
      checks++;
      if ({count_val, dir, ovf_pulse, unf_pulse, upd_pulse, done} !==
          {c, d, o, u, up, dn}) begin
         errors++;
         $display("FAIL %s: got cnt=%0d dir=%b ovf=%b unf=%b upd=%b done=%b, need cnt=%0d dir=%b ovf=%b unf=%b upd=%b done=%b",
                  name, count_val, dir, ovf_pulse, unf_pulse, upd_pulse, done,
                  c, d, o, u, up, dn);
      end
   endtask

   task automatic add(input logic e, input logic cr, input logic [1:0] m,
                      input logic [CW-1:0] p, input logic [PW-1:0] ps,
                      input logic os, input logic [CW-1:0] c, input logic d,
                      input logic o, input logic u, input logic up,
                      input logic dn);
      vec_t v;
      v = '{e, cr, m, p, ps, os, c, d, o, u, up, dn};
      tv.push_back(v);
   endtask

   initial begin
      rst_n = 1'b0;
`ifdef PWM_CNT_REPEAT_EN
      repeat_val = 8'd0;
`endif
      drive(1'b1, 1'b0, 2'b01, 8'd3, 4'd2, 1'b1);
      step();
      expect_out("reset", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // shadows reset to P=0, prescale 0, up: first tick wraps and loads inputs
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 2'b00, 8'd3, 4'd0, 1'b0);
      expect_out("rst_shadow_wrap", 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 2'b00, 8'd3, 4'd0, 1'b0);
      expect_out("rst_shadow_load", 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // up, P=3
      add(1, 1, 2'b00, 3, 0, 0, 0, 1, 0, 0, 0, 0);
      add(1, 0, 2'b00, 3, 0, 0, 1, 1, 0, 0, 0, 0);
      add(1, 0, 2'b00, 3, 0, 0, 2, 1, 0, 0, 0, 0);
      add(1, 0, 2'b00, 3, 0, 0, 3, 1, 0, 0, 0, 0);
      add(1, 0, 2'b00, 3, 0, 0, 0, 1, 1, 0, 1, 0);
      add(1, 0, 2'b00, 3, 0, 0, 1, 1, 0, 0, 0, 0);
      // centre, P=3
      add(1, 1, 2'b10, 3, 0, 0, 0, 1, 0, 0, 0, 0);
      add(1, 0, 2'b10, 3, 0, 0, 1, 1, 0, 0, 0, 0);
      add(1, 0, 2'b10, 3, 0, 0, 2, 1, 0, 0, 0, 0);
      add(1, 0, 2'b10, 3, 0, 0, 3, 1, 0, 0, 0, 0);
      add(1, 0, 2'b10, 3, 0, 0, 2, 0, 1, 0, 0, 0);
      add(1, 0, 2'b10, 3, 0, 0, 1, 0, 0, 0, 0, 0);
      add(1, 0, 2'b10, 3, 0, 0, 0, 0, 0, 0, 0, 0);
      add(1, 0, 2'b10, 3, 0, 0, 1, 1, 0, 1, 1, 0);
      // centre, P=1
      add(1, 1, 2'b10, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      add(1, 0, 2'b10, 1, 0, 0, 1, 1, 0, 0, 0, 0);
      add(1, 0, 2'b10, 1, 0, 0, 0, 0, 1, 0, 0, 0);
      add(1, 0, 2'b10, 1, 0, 0, 1, 1, 0, 1, 1, 0);
      add(1, 0, 2'b10, 1, 0, 0, 0, 0, 1, 0, 0, 0);
      // centre, P=0
      add(1, 1, 2'b10, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      add(1, 0, 2'b10, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      add(1, 0, 2'b10, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      // mode 11 behaves as up, P=1
      add(1, 1, 2'b11, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      add(1, 0, 2'b11, 1, 0, 0, 1, 1, 0, 0, 0, 0);
      add(1, 0, 2'b11, 1, 0, 0, 0, 1, 1, 0, 1, 0);

      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i].en, tv[i].cr, tv[i].mode, tv[i].per, tv[i].psc, tv[i].os);
         expect_out($sformatf("vec%0d", i), tv[i].cnt, tv[i].dir, tv[i].ovf,
                    tv[i].unf, tv[i].upd, tv[i].done);
      end

      // down, P=2, prescale=1: 2,2,1,1,0,0,2
      drive(1'b1, 1'b1, 2'b01, 8'd2, 4'd1, 1'b0);
      expect_out("dn_cr", 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 2'b01, 8'd2, 4'd1, 1'b0);
      expect_out("dn_a", 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 2'b01, 8'd2, 4'd1, 1'b0);
      expect_out("dn_b", 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 2'b01, 8'd2, 4'd1, 1'b0);
      expect_out("dn_c", 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 2'b01, 8'd2, 4'd1, 1'b0);
      expect_out("dn_d", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 2'b01, 8'd2, 4'd1, 1'b0);
      expect_out("dn_e", 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // reload takes the new period 4 presented at the update
      drive(1'b1, 1'b0, 2'b01, 8'd4, 4'd1, 1'b0);
      expect_out("dn_reload", 8'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 2'b01, 8'd4, 4'd1, 1'b0);
      expect_out("dn_hold", 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // shadow + one-shot: P 3->5 mid-period, old P completes, halt at 0
      drive(1'b1, 1'b1, 2'b00, 8'd3, 4'd0, 1'b1);
      drive(1'b1, 1'b0, 2'b00, 8'd3, 4'd0, 1'b1);
      expect_out("os_1", 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 2'b00, 8'd5, 4'd0, 1'b0);
      drive(1'b1, 1'b0, 2'b00, 8'd5, 4'd0, 1'b0);
      expect_out("os_old_p", 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 2'b00, 8'd5, 4'd0, 1'b0);
      expect_out("os_wrap", 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 2'b00, 8'd5, 4'd0, 1'b0);
      drive(1'b1, 1'b0, 2'b00, 8'd5, 4'd0, 1'b0);
      expect_out("os_halted", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 2'b00, 8'd5, 4'd0, 1'b0);
      expect_out("os_cr", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 2'b00, 8'd5, 4'd0, 1'b0);
      expect_out("os_p5_top", 8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 2'b00, 8'd5, 4'd0, 1'b0);
      expect_out("os_p5_wrap", 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

      // freeze at count 2, then resume
      drive(1'b1, 1'b1, 2'b00, 8'd5, 4'd0, 1'b0);
      drive(1'b1, 1'b0, 2'b00, 8'd5, 4'd0, 1'b0);
      drive(1'b1, 1'b0, 2'b00, 8'd5, 4'd0, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 2'b00, 8'd5, 4'd0, 1'b0);
      expect_out("freeze", 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 2'b00, 8'd5, 4'd0, 1'b0);
      expect_out("resume", 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 2'b00, 8'd5, 4'd0, 1'b0);
      drive(1'b1, 1'b0, 2'b00, 8'd5, 4'd0, 1'b0);
      expect_out("pri_top", 8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 2'b00, 8'd5, 4'd0, 1'b0);
      expect_out("pri_cr_tick", 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // extreme period 2^CW-1
      drive(1'b1, 1'b1, 2'b00, 8'hFF, 4'd0, 1'b0);
      for (int i = 0; i < 255; i++) drive(1'b1, 1'b0, 2'b00, 8'hFF, 4'd0, 1'b0);
      expect_out("max_top", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 2'b00, 8'hFF, 4'd0, 1'b0);
      expect_out("max_wrap", 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

`ifdef PWM_CNT_REPEAT_EN
      // repeat=2, up P=1: ovf every 2 ticks, upd on every 3rd ovf
      repeat_val = 8'd2;
      drive(1'b1, 1'b1, 2'b00, 8'd1, 4'd0, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         drive(1'b1, 1'b0, 2'b00, 8'd1, 4'd0, 1'b0);
         expect_out($sformatf("rep_up%0d", k), 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         drive(1'b1, 1'b0, 2'b00, 8'd1, 4'd0, 1'b0);
         expect_out($sformatf("rep_ovf%0d", k), 8'd0, 1'b1, 1'b1, 1'b0,
                    (k % 3 == 0), 1'b0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_counter_gen.md
Name: pwm_counter_gen

Overview:
Parametrised successor to the single-mode PWM timebase counter. It generates the count value for the PWM comparators. It supports three counting modes: up, down and centre-aligned up/down. Period, prescale and mode are shadowed and reloaded only at update events. It adds overflow, underflow and update event pulses, plus a one-shot mode. The block sits between the register file and the compare/output channels.

Parameters:
CNT_W, 16, counter and period width in bits (2..32).
PSC_W, 8, prescaler width in bits (1..16).

Ports:
clk  in  1  peripheral clock.
rst_n  in  1  reset, synchronous, active-low; sampled on posedge clk.
en  in  1  count enable; when low, count and prescaler hold.
count_reset  in  1  synchronous clear and shadow load; priority over en.
mode  in  2  00 up, 01 down, 10 up/down centre-aligned, 11 treated as up.
period  in  CNT_W  terminal value P (shadowed).
prescale  in  PSC_W  clock divide minus one (shadowed).
one_shot  in  1  stop after first update event (shadowed).
count_val  out  CNT_W  current count.
dir  out  1  1 = counting up, 0 = counting down.
ovf_pulse  out  1  one-cycle pulse, top-of-count event.
unf_pulse  out  1  one-cycle pulse, bottom-of-count event.
upd_pulse  out  1  one-cycle pulse, update event (shadows reloaded).
done  out  1  one-shot completed, counter halted.

Behaviour:
- Reset (rst_n=0 at posedge), all outputs: count_val=0, dir=1, all pulses=0, done=0, prescaler=0.
- Reset shadows: period=0, prescale=0, mode=00, one_shot=0.
- count_reset=1 loads all shadows from the inputs and clears the prescaler, pulses and done.
  - count_val is set to shadow P if the incoming mode=01, else 0.
  - dir is set to 0 for mode 01, else 1.
- Prescaler: psc_cnt increments on each en cycle. Tick when psc_cnt==prescale_sh, which also sets psc_cnt to 0. prescale=0 means tick every enabled cycle.
- All count changes and pulses occur only on tick cycles. Pulses are registered and assert in the same cycle count_val takes its wrapped value.
- Up mode, on tick:
  - count < P: count+1.
  - count >= P: count=0, ovf_pulse.
- Down mode, on tick:
  - count > 0: count-1.
  - count == 0: count=P_sh, unf_pulse.
  - Reload uses the newly loaded P when coincident with an update.
- Up/down mode, on tick:
  - dir=1 and count < P: count+1.
  - dir=1 and count >= P: count=P-1, dir=0, ovf_pulse.
  - dir=0 and count > 0: count-1.
  - dir=0 and count == 0: count=1, dir=1, unf_pulse.
  - P=0: count stays 0, dir stays 1, ovf_pulse on every tick.
  - P=1: sequence 0,1,0,1.
- Update event:
  - up: every wrap.
  - down: every reload.
  - up/down: every unf (bottom only).
  - On update: shadows reload from inputs and upd_pulse asserts with the event pulse.
- Mode change takes effect only at an update event or count_reset.
- Arithmetic is CNT_W-bit unsigned. P = 2^CNT_W-1 must wrap correctly with no overflow past P.
- One-shot: if one_shot_sh=1 at an update event, the counter halts at the wrapped value and done=1.
  - While halted, the prescaler stops and no further pulses are produced.
  - done clears only on count_reset or reset.
- en=0 mid-period freezes count, dir and psc_cnt. Resuming continues exactly where it stopped.
- Simultaneous count_reset and tick: count_reset wins and no pulses are produced.

Optional Feature:
Macro PWM_CNT_REPEAT_EN.
- Defined:
  - Adds input repeat[7:0], shadowed like period, and an internal repetition counter.
  - ovf/unf still pulse on every wrap.
  - An update event (shadow reload, upd_pulse, one-shot stop) occurs only on every (repeat_sh+1)-th base update event.
  - The repetition counter clears on reset and on count_reset.
- Not defined: no repeat port; every base update event is an update event.

Test Plan:
- Up count, settings: mode=00, P=3, prescale=0, en=1. Required response:
  - count_val 0,1,2,3,0,...
  - ovf_pulse in the cycle count returns to 0.
  - upd_pulse coincides with ovf_pulse.
- Down count with prescale, settings: mode=01, P=2, prescale=1, after count_reset. Required response:
  - count_val 2,2,1,1,0,0,2.
  - unf_pulse once per reload.
- Centre-aligned, settings: mode=10, P=3. Required response:
  - count_val 0,1,2,3,2,1,0,1.
  - dir falls when count leaves 3.
  - ovf_pulse at the 3→2 turn, unf_pulse plus upd_pulse at the 0→1 turn.
- Shadow and one-shot: change period 3→5 mid-period with one_shot=1. Required response:
  - Old P=3 completes.
  - Halt at 0, done=1, no further pulses.
  - count_reset then runs with P=5.
- Freeze and priority:
  - en=0 for 4 cycles at count=2 → count stays 2, resumes to 3.
  - count_reset together with a tick → count=0, no pulses.
- Repeat and extreme period:
  - Repeat (macro defined): repeat=2 → upd_pulse on every 3rd ovf.
  - Extreme period: P=2^CNT_W-1 → up-mode wraps to 0 with ovf.
